ramio_arbiter: RTL
==================

# ramio_arbiter

Two-master arbiter that shares the single `ramio` memory port between the rv32i core (master 0) and a second requester such as a DMA or debug loader (master 1). Each master sees a private copy of the `ramio` handshake (enable, read/write type, address, data, ready, busy). The arbiter captures requests, grants the downstream port round-robin and runs one transaction at a time. It returns read data and completion status to the owning master, and flags a sticky error if the memory never answers.

## Interface
- `TimeoutCycles`, default 1024: maximum downstream wait cycles per transaction. 0 disables the timeout.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `m0_enable`, `m1_enable`  in  1  master request enable
- `m0_read_type`, `m1_read_type`  in  3  0 = no read; bit2 = signed; [1:0] 01 byte, 10 half, 11 word
- `m0_write_type`, `m1_write_type`  in  2  0 = no write; 01 byte, 10 half, 11 word
- `m0_address`, `m1_address`  in  32  byte address
- `m0_data_in`, `m1_data_in`  in  32  write data
- `m0_data_out`, `m1_data_out`  out  32  last read data returned to that master (registered)
- `m0_data_out_ready`, `m1_data_out_ready`  out  1  one-cycle read-completion pulse (registered)
- `m0_busy`, `m1_busy`  out  1  request pending or in flight (combinational, see Timing)
- `ramio_enable`  out  1  downstream enable
- `ramio_read_type`  out  3  downstream read type
- `ramio_write_type`  out  2  downstream write type
- `ramio_address`  out  32  downstream address
- `ramio_data_in`  out  32  downstream write data
- `ramio_data_out`  in  32  downstream read data
- `ramio_data_out_ready`  in  1  downstream read complete
- `ramio_busy`  in  1  downstream busy
- `timeout_error`  out  1  sticky; set on any timeout, cleared only by reset

## Operation
- **Request classification.** A request is `enable=1` with `write_type!=0` (write; `read_type` ignored) or with `write_type==0 && read_type!=0` (read). `enable=1` with both types zero is no request.
- **Per-port state.** Each port is IDLE, PEND or DONE.
  - IDLE→PEND when a request is present. The port captures type, address and data.
  - PEND→DONE on completion.
  - DONE→IDLE when `enable=0`, or when any of {read_type, write_type, address, data_in} differs from the captured request. A differing request moves the port straight to PEND.
  - A request held unchanged in DONE is the same transaction and is not reissued. This is a documented limitation.
- **Grant.** Round-robin via a `last_grant` register (reset value 1, so master 0 wins the first tie). A sole pending port wins. On a tie, the port not in `last_grant` wins. `last_grant` updates on issue.
- **Main FSM states:** IDLE, READ_WAIT, WRITE_HOLD, WRITE_WAIT.
  - IDLE: if any port is PEND and `ramio_busy=0`, register the granted request onto `ramio_*` with `ramio_enable=1`. Go to READ_WAIT or WRITE_HOLD.
  - READ_WAIT: on `ramio_data_out_ready`, copy `ramio_data_out` into the owner's `data_out`, pulse the owner's `data_out_ready`, set `ramio_enable=0` and the types to 0, mark the port DONE, go to IDLE.
  - WRITE_HOLD: unconditional single cycle, so the memory can raise busy. Go to WRITE_WAIT.
  - WRITE_WAIT: on `ramio_busy=0`, set `ramio_enable=0` and the types to 0, mark the port DONE, go to IDLE.
- **Timeout.** A 16-bit wait counter clears on issue and increments in READ_WAIT, WRITE_HOLD and WRITE_WAIT. When it reaches `TimeoutCycles` (non-zero):
  - set `timeout_error`;
  - complete the transaction as above; a read returns data 0 with a ready pulse;
  - go to IDLE.

## Timing
- **Reset values.** All outputs are 0; all ports IDLE; FSM IDLE; `last_grant=1`; counter 0. Reset mid-transaction abandons it with no completion pulse.
- **`mN_busy`** = (port PEND) OR (port IDLE/DONE with a new request visible this cycle). It is therefore high in the same cycle a master first presents a request, and low from the cycle after completion.
- **Minimum read latency.** Request visible at cycle t; `ramio_enable` at t+1; memory ready at t+k; `mN_data_out_ready` at t+k+1.
- **Minimum write latency.** Issue at t+1; WRITE_HOLD at t+1; `mN_busy` low at t+3 at the earliest.
- **Back-to-back.** Completion and the next issue never share a cycle. `ramio_enable` drops for at least one cycle between transactions.
- **Other port.** A request arriving while the other port is active stays PEND with `busy=1` until granted.

## Test plan
- **Single read.** m0 reads word 0x100 (type 111); memory asserts ready with 0xDEADBEEF 3 cycles after issue. Required: `m0_data_out_ready` pulses 1 cycle later with `m0_data_out=0xDEADBEEF`, `ramio_enable=0` the same cycle, `m1_data_out_ready` never set.
- **Simultaneous after reset.** m0 reads 0x0 and m1 writes 0x55 to 0x200. Required: m0 issued first, m1 second, `m1_busy` high until its write completes. A second tie is then granted to m0 (last_grant=m1).
- **Core store→fetch pattern.** m0 keeps `enable=1` and changes from SW 0x10←0x1234 to read type 111 at 0x8. Required: exactly two downstream transactions, the write before the read.
- **Slow write.** Memory holds `ramio_busy` for 5 cycles after issue. Required: `m0_busy` high throughout, low the cycle after FSM completion, no reissue while the request is held unchanged.
- **Timeout.** `TimeoutCycles=8`, read never answered. Required: after 8 wait cycles `timeout_error=1` (sticky), `m0_data_out_ready` pulse with data 0, and a following m1 request served normally.
- **Reset mid-read.** Required: next cycle all outputs 0, no ready pulse, and a fresh request afterwards completes normally.

Source files
------------

// File: rtl/ramio_arbiter_if.sv
// ramio_arbiter_if -- one copy of the ramio memory handshake.
//
// The same bundle describes both sides of the arbiter:
//   master modport : the requester (core, DMA, or the arbiter itself towards
//                    the memory). Drives enable/read_type/write_type/address/
//                    data_in and receives data_out/data_out_ready/busy.
//   slave modport  : the responder (the memory, or the arbiter towards each
//                    requester).
//
// Signals:
//   enable          request enable
//   read_type [2:0] 0 = no read; bit2 = signed; [1:0] 01 byte, 10 half, 11 word
//   write_type[1:0] 0 = no write; 01 byte, 10 half, 11 word
//   address  [31:0] byte address
//   data_in  [31:0] write data
//   data_out [31:0] read data
//   data_out_ready  read completion
//   busy            responder busy / request outstanding
interface ramio_arbiter_if;
  logic        enable;
  logic [2:0]  read_type;
  logic [1:0]  write_type;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;

  modport master (
    output enable, read_type, write_type, address, data_in,
    input  data_out, data_out_ready, busy
  );

  modport slave (
    input  enable, read_type, write_type, address, data_in,
    output data_out, data_out_ready, busy
  );
endinterface

// File: rtl/ramio_arbiter.sv
// ramio_arbiter -- shares one ramio memory port between two masters.
//
// Master 0 (rv32i core) and master 1 (DMA / debug loader) each get a private
// ramio handshake. Requests are captured per port, granted round-robin and
// executed one at a time on the downstream port. Read data and completion go
// back to the owning master; a sticky flag records any memory timeout.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   m0, m1         per-master handshakes (slave side of ramio_arbiter_if);
//                  busy is combinational, data_out/data_out_ready registered
//   ramio          downstream memory port (master side), all outputs registered
//   timeout_error  sticky, set on any timeout, cleared only by reset
//
// TimeoutCycles: maximum wait cycles per transaction, 0 disables the timeout.
module ramio_arbiter #(
  parameter int TimeoutCycles = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ramio_arbiter_if.slave         m0,
  ramio_arbiter_if.slave         m1,
  ramio_arbiter_if.master        ramio,
  output logic                   timeout_error
);

  typedef enum logic [1:0] {P_IDLE, P_PEND, P_DONE} port_state_e;
  typedef enum logic [1:0] {S_IDLE, S_READ_WAIT, S_WRITE_HOLD, S_WRITE_WAIT} state_e;

  typedef struct packed {
    logic [2:0]  read_type;
    logic [1:0]  write_type;
    logic [31:0] address;
    logic [31:0] data_in;
  } req_t;

  localparam logic [15:0] TIMEOUT = 16'(TimeoutCycles);

  // Live requests as presented by each master this cycle.
  req_t       live [2];
  logic [1:0] en;

  assign live[0] = {m0.read_type, m0.write_type, m0.address, m0.data_in};
  assign live[1] = {m1.read_type, m1.write_type, m1.address, m1.data_in};
  assign en      = {m1.enable, m0.enable};

  // Registered state.
  port_state_e pst_q [2];
  req_t        cap_q [2];
  logic [31:0] dout_q [2];
  logic [1:0]  rdy_q;
  state_e      state_q;
  logic        owner_q;
  logic        last_grant_q;
  logic [15:0] wait_cnt_q;
  logic        ramio_en_q;
  req_t        ramio_q;

  // Request decode, grant and completion.
  logic [1:0]  has_req;
  logic [1:0]  new_req;
  logic [1:0]  pend;
  logic        gnt;
  req_t        sel;
  logic        sel_is_write;
  logic [15:0] wait_next;
  logic        normal_done;
  logic        timeout_hit;
  logic        complete;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    has_req = '0;
    new_req = '0;
    pend    = '0;
    for (int i = 0; i < 2; i++) begin
      has_req[i] = en[i] && (live[i].write_type != 2'b00 || live[i].read_type != 3'b000);
      // In DONE only a request that differs from the captured one is new;
      // an unchanged request is the transaction that already completed.
      new_req[i] = has_req[i] &&
                   (pst_q[i] == P_IDLE || (pst_q[i] == P_DONE && live[i] != cap_q[i]));
      pend[i]    = (pst_q[i] == P_PEND) || new_req[i];
    end

    // Sole requester wins; on a tie the port that did not win last time.
    gnt = (pend == 2'b11) ? ~last_grant_q : pend[1];

    // A port seen for the first time this cycle has not been captured yet,
    // so issue straight from its live inputs.
    sel = live[gnt];
    if (pst_q[gnt] == P_PEND) sel = cap_q[gnt];
    sel_is_write = (sel.write_type != 2'b00);

    wait_next   = wait_cnt_q + 16'd1;
    normal_done = (state_q == S_READ_WAIT  && ramio.data_out_ready) ||
                  (state_q == S_WRITE_WAIT && !ramio.busy);
    // A genuine memory answer in the same cycle takes precedence.
    timeout_hit = (state_q != S_IDLE) && (TIMEOUT != 16'd0) &&
                  (wait_next == TIMEOUT) && !normal_done;
    complete    = normal_done || timeout_hit;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      wait_cnt_q    <= '0;
      ramio_en_q    <= 1'b0;
      ramio_q       <= '0;
      rdy_q         <= '0;
      timeout_error <= 1'b0;
      // NOTE: the capture and read-data registers are small and drive
      // outputs/comparisons directly, so they are reset like any flop.
      for (int i = 0; i < 2; i++) begin
        pst_q[i]  <= P_IDLE;
        cap_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      rdy_q <= '0;

      for (int i = 0; i < 2; i++) begin
        case (pst_q[i])
          P_IDLE: begin
            if (has_req[i]) begin
              pst_q[i] <= P_PEND;
              cap_q[i] <= live[i];
            end
          end
          P_PEND: begin
            if (complete && owner_q == 1'(i)) pst_q[i] <= P_DONE;
          end
          P_DONE: begin
            if (new_req[i]) begin
              pst_q[i] <= P_PEND;
              cap_q[i] <= live[i];
            end else if (!en[i] || live[i] != cap_q[i]) begin
              pst_q[i] <= P_IDLE;
            end
          end
          default: pst_q[i] <= P_IDLE;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if ((pend != 2'b00) && !ramio.busy) begin
            ramio_en_q   <= 1'b1;
            // read_type is meaningless on a write, keep it off the bus.
            ramio_q      <= '{read_type:  sel_is_write ? 3'b000 : sel.read_type,
                              write_type: sel.write_type,
                              address:    sel.address,
                              data_in:    sel.data_in};
            owner_q      <= gnt;
            last_grant_q <= gnt;
            wait_cnt_q   <= '0;
            state_q      <= sel_is_write ? S_WRITE_HOLD : S_READ_WAIT;
          end
        end
        default: begin
          wait_cnt_q <= wait_next;
          if (complete) begin
            ramio_en_q         <= 1'b0;
            ramio_q.read_type  <= 3'b000;
            ramio_q.write_type <= 2'b00;
            state_q            <= S_IDLE;
            if (timeout_hit) timeout_error <= 1'b1;
            if (state_q == S_READ_WAIT) begin
              dout_q[owner_q] <= timeout_hit ? 32'h0 : ramio.data_out;
              rdy_q[owner_q]  <= 1'b1;
            end
          end else if (state_q == S_WRITE_HOLD) begin
            // One cycle for the memory to raise busy before we look at it.
            state_q <= S_WRITE_WAIT;
          end
        end
      endcase
    end
  end

  assign m0.data_out       = dout_q[0];
  assign m1.data_out       = dout_q[1];
  assign m0.data_out_ready = rdy_q[0];
  assign m1.data_out_ready = rdy_q[1];
  assign m0.busy           = pend[0];
  assign m1.busy           = pend[1];

  assign ramio.enable     = ramio_en_q;
  assign ramio.read_type  = ramio_q.read_type;
  assign ramio.write_type = ramio_q.write_type;
  assign ramio.address    = ramio_q.address;
  assign ramio.data_in    = ramio_q.data_in;

endmodule
